// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port merger.
// Entry layout and widths of the load-return queue.
package wb_pkg;
  localparam int REG_W = 4;
  localparam int DATA_W = 16;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_storage.sv
// Load-return entry array: tail write, head read,
// squash-by-register and two-port pending compare.
module wbq_storage
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [AW-1:0]    tail,
  input  wbq_entry_t       wentry,
  input  logic             pop,
  input  logic [AW-1:0]    head_idx,
  output wbq_entry_t       head,
  input  logic             squash,
  input  logic [REG_W-1:0] squash_reg,
  input  logic [REG_W-1:0] chk_reg1,
  input  logic [REG_W-1:0] chk_reg2,
  output logic             pending1,
  output logic             pending2
);

  wbq_entry_t mem [DEPTH];

  // Later assignments win: squash, then pop-kill, then fresh push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && mem[i].dst == squash_reg)
          mem[i].live <= 1'b0;
      end
      if (pop) mem[head_idx].live <= 1'b0;
      if (push) mem[tail] <= wentry;
    end
  end

  assign head = mem[head_idx];

  logic hit1, hit2;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 | (mem[i].live && mem[i].dst == chk_reg1);
      hit2 = hit2 | (mem[i].live && mem[i].dst == chk_reg2);
    end
  end

  assign pending1 = hit1 && (chk_reg1 != REG_ZERO);
  assign pending2 = hit2 && (chk_reg2 != REG_ZERO);

endmodule

// File: rtl/reg_writeback_merge.sv
// Merges pipeline writeback and late load returns onto the
// register file write port. Optional bypass: WBQ_BYPASS_EN.
module reg_writeback_merge #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 16,
  parameter int REG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_W-1:0]  chk_reg1,
  input  logic [REG_W-1:0]  chk_reg2,
  output logic              pending1,
  output logic              pending2,
  output logic              WriteReg,
  output logic [REG_W-1:0]  DstReg,
  output logic [DATA_W-1:0] DstData,
  output logic              empty
);
  import wb_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop, bypass, squash;
  wbq_entry_t    wentry, head;

  assign mem_ready = cnt_q < CW'(DEPTH);
  assign empty     = cnt_q == '0;

`ifdef WBQ_BYPASS_EN
  assign bypass = empty && !pipe_we && mem_valid
               && mem_reg != REG_ZERO;
`else
  assign bypass = 1'b0;
`endif

  assign push   = mem_valid && mem_ready && !bypass;
  assign pop    = !pipe_we && !empty;
  assign squash = pipe_we && pipe_reg != REG_ZERO;

  // A same-cycle pipeline write to the same register is younger.
  assign wentry.live = (mem_reg != REG_ZERO)
                    && !(pipe_we && pipe_reg == mem_reg);
  assign wentry.dst  = mem_reg;
  assign wentry.data = mem_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  wbq_storage #(.DEPTH(DEPTH)) u_store (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .tail       (tail_q),
    .wentry     (wentry),
    .pop        (pop),
    .head_idx   (head_q),
    .head       (head),
    .squash     (squash),
    .squash_reg (pipe_reg),
    .chk_reg1   (chk_reg1),
    .chk_reg2   (chk_reg2),
    .pending1   (pending1),
    .pending2   (pending2)
  );

  always_comb begin
    WriteReg = 1'b0;
    DstReg   = '0;
    DstData  = '0;
    unique case (1'b1)
      pipe_we: begin
        WriteReg = 1'b1;
        DstReg   = pipe_reg;
        DstData  = pipe_data;
      end
      (pop && head.live): begin
        WriteReg = 1'b1;
        DstReg   = head.dst;
        DstData  = head.data;
      end
      bypass: begin
        WriteReg = 1'b1;
        DstReg   = mem_reg;
        DstData  = mem_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_writeback_merge.sv
// Directed vector bench for reg_writeback_merge.
// One vector per clock cycle; outputs checked mid-cycle.
module tb_reg_writeback_merge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [3:0]  pipe_reg = '0;
  logic [15:0] pipe_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_reg = '0;
  logic [15:0] mem_data = '0;
  logic [3:0]  chk_reg1 = '0;
  logic [3:0]  chk_reg2 = '0;
  logic        pending1, pending2;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        empty;

  int total = 0;
  int bad = 0;
  logic [15:0] rf [16];

  always #5 clk = ~clk;

  reg_writeback_merge #(.DEPTH(4), .DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg(mem_reg), .mem_data(mem_data),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .pending1(pending1), .pending2(pending2),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .empty(empty)
  );

  typedef struct {
    logic        pw;
    logic [3:0]  pr;
    logic [15:0] pd;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] md;
    logic [3:0]  c1;
    logic [3:0]  c2;
    logic        e_we;
    logic [3:0]  e_reg;
    logic [15:0] e_data;
    logic        e_rdy;
    logic        e_emp;
    logic        e_p1;
    logic        e_p2;
  } vec_t;

  vec_t v [$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h",
               name, idx, act, exp);
    end
  endtask

  task automatic add(input logic pw, input logic [3:0] pr,
                     input logic [15:0] pd, input logic mv,
                     input logic [3:0] mr, input logic [15:0] md,
                     input logic [3:0] c1, input logic [3:0] c2,
                     input logic e_we, input logic [3:0] e_reg,
                     input logic [15:0] e_data, input logic e_rdy,
                     input logic e_emp, input logic e_p1,
                     input logic e_p2);
    vec_t t;
    t = '{pw, pr, pd, mv, mr, md, c1, c2,
          e_we, e_reg, e_data, e_rdy, e_emp, e_p1, e_p2};
    v.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    pipe_we   = t.pw;
    pipe_reg  = t.pr;
    pipe_data = t.pd;
    mem_valid = t.mv;
    mem_reg   = t.mr;
    mem_data  = t.md;
    chk_reg1  = t.c1;
    chk_reg2  = t.c2;
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    chk_reg1 = '0; chk_reg2 = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // single load to R3
`ifdef WBQ_BYPASS_EN
    add(0,0,0, 1,3,16'h1234, 3,0, 1,3,16'h1234, 1,1,0,0);
    add(0,0,0, 0,0,0,        3,0, 0,0,0,        1,1,0,0);
`else
    add(0,0,0, 1,3,16'h1234, 3,0, 0,0,0,        1,1,0,0);
    add(0,0,0, 0,0,0,        3,0, 1,3,16'h1234, 1,0,1,0);
`endif
    add(0,0,0, 0,0,0,        3,0, 0,0,0,        1,1,0,0);
    // priority: R5 queued behind 3 pipeline writes
    add(1,2,16'h0001, 1,5,16'hAAAA, 5,2, 1,2,16'h0001, 1,1,0,0);
    add(1,2,16'h0001, 0,0,0,        5,2, 1,2,16'h0001, 1,0,1,0);
    add(1,2,16'h0001, 0,0,0,        5,2, 1,2,16'h0001, 1,0,1,0);
    add(0,0,0,        0,0,0,        5,2, 1,5,16'hAAAA, 1,0,1,0);
    add(0,0,0,        0,0,0,        5,2, 0,0,0,        1,1,0,0);
    // squash: R7 load overtaken by pipeline R7 write
    add(1,15,16'h00FF, 1,7,16'h1111, 7,0, 1,15,16'h00FF, 1,1,0,0);
    add(1,7,16'h2222,  0,0,0,        7,0, 1,7,16'h2222,  1,0,1,0);
    add(0,0,0,         0,0,0,        7,0, 0,0,0,         1,0,0,0);
    add(0,0,0,         0,0,0,        7,0, 0,0,0,         1,1,0,0);
    // load to R0 is accepted but never written
    add(0,0,0, 1,0,16'h5555, 0,0, 0,0,0, 1,1,0,0);
    add(0,0,0, 0,0,0,        0,0, 0,0,0, 1,0,0,0);
    add(0,0,0, 0,0,0,        0,0, 0,0,0, 1,1,0,0);
    // full: four loads under pipeline writes, fifth waits
    add(1,15,16'hF0F0, 1,1,16'h0101, 1,4, 1,15,16'hF0F0, 1,1,0,0);
    add(1,15,16'hF0F0, 1,2,16'h0202, 1,4, 1,15,16'hF0F0, 1,0,1,0);
    add(1,15,16'hF0F0, 1,3,16'h0303, 1,4, 1,15,16'hF0F0, 1,0,1,0);
    add(1,15,16'hF0F0, 1,4,16'h0404, 1,4, 1,15,16'hF0F0, 1,0,1,0);
    add(1,15,16'hF0F0, 1,5,16'h0505, 1,4, 1,15,16'hF0F0, 0,0,1,1);
    add(0,0,0,         1,5,16'h0505, 1,5, 1,1,16'h0101,  0,0,1,0);
    add(0,0,0,         1,5,16'h0505, 1,5, 1,2,16'h0202,  1,0,0,0);
    add(0,0,0,         0,0,0,        1,5, 1,3,16'h0303,  1,0,0,1);
    add(0,0,0,         0,0,0,        1,5, 1,4,16'h0404,  1,0,0,1);
    add(0,0,0,         0,0,0,        1,5, 1,5,16'h0505,  1,0,0,1);
    add(0,0,0,         0,0,0,        1,5, 0,0,0,         1,1,0,0);

    // reset state, sampled before any clock edge
    #2;
    check("rst_ready", -1, 32'(mem_ready), 32'd1);
    check("rst_empty", -1, 32'(empty), 32'd1);
    check("rst_we",    -1, 32'(WriteReg), 32'd0);
    check("rst_reg",   -1, 32'(DstReg), 32'd0);
    check("rst_data",  -1, 32'(DstData), 32'd0);
    check("rst_pend",  -1, 32'({pending1, pending2}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      check("we",    i, 32'(WriteReg),  32'(v[i].e_we));
      check("reg",   i, 32'(DstReg),    32'(v[i].e_reg));
      check("data",  i, 32'(DstData),   32'(v[i].e_data));
      check("ready", i, 32'(mem_ready), 32'(v[i].e_rdy));
      check("empty", i, 32'(empty),     32'(v[i].e_emp));
      check("pend1", i, 32'(pending1),  32'(v[i].e_p1));
      check("pend2", i, 32'(pending2),  32'(v[i].e_p2));
      if (WriteReg) rf[DstReg] = DstData;
    end
    check("rf_r7_kept", 99, 32'(rf[7]), 32'h2222);
    check("rf_r5",      99, 32'(rf[5]), 32'h0505);

    // mid-operation reset with three loads queued
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pipe_we = 1'b1; pipe_reg = 4'd15; pipe_data = 16'h0F0F;
      mem_valid = 1'b1; mem_reg = 4'(8 + k);
      mem_data = 16'(16'h0800 + k);
    end
    @(negedge clk);
    idle();
    chk_reg1 = 4'd8;
    chk_reg2 = 4'd10;
    #1;
    check("pre_rst_empty", 200, 32'(empty), 32'd0);
    check("pre_rst_pend",  200, 32'(pending1), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_empty", 201, 32'(empty), 32'd1);
    check("mid_rst_we",    201, 32'(WriteReg), 32'd0);
    check("mid_rst_ready", 201, 32'(mem_ready), 32'd1);
    check("mid_rst_pend",  201, 32'({pending1, pending2}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_we",    300 + k, 32'(WriteReg), 32'd0);
      check("post_rst_empty", 300 + k, 32'(empty), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback_merge.md
# reg_writeback_merge

Write-port merger placed directly upstream of the 16×16 register file. It owns the file's single write port (`WriteReg`, `DstReg`, `DstData`). Each cycle it selects between the in-order pipeline writeback and a small FIFO of late load results returning from the data cache after a miss. It also reports which registers still have a buffered write pending, so decode can stall readers.

## Interface
Parameters:
- `DEPTH`, 4: load-return FIFO entries; power of two, at least 2.
- `DATA_W`, 16: register data width.
- `REG_W`, 4: register index width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pipe_we`  in  1  pipeline writeback valid; always has priority on the write port.
- `pipe_reg`  in  REG_W  pipeline destination register.
- `pipe_data`  in  DATA_W  pipeline write data.
- `mem_valid`  in  1  cache load return offered.
- `mem_ready`  out  1  return accepted this cycle when `mem_valid` is also high.
- `mem_reg`  in  REG_W  load destination register.
- `mem_data`  in  DATA_W  load data.
- `chk_reg1`, `chk_reg2`  in  REG_W  decode source registers to check.
- `pending1`, `pending2`  out  1  a live queued write targets `chk_regN`.
- `WriteReg`  out  1  register file write enable.
- `DstReg`  out  REG_W  register file write index.
- `DstData`  out  DATA_W  register file write data.
- `empty`  out  1  FIFO holds no entries.

## Operation
- **FIFO state.** Each entry holds `{live, reg, data}`. There is a head pointer, a tail pointer and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- **Enqueue.** `mem_ready` = count < DEPTH and is computed from registered state only; it does not depend on a same-cycle pop.
  - A handshake (`mem_valid & mem_ready`) writes the tail entry and advances the tail.
  - `live` = (`mem_reg` ≠ 0) and not (`pipe_we` and `pipe_reg` == `mem_reg`).
  - A same-cycle pipeline write to the same register is younger, so the load entry is stored dead.
- **Squash.** When `pipe_we` is high and `pipe_reg` ≠ 0, every stored entry with a matching `reg` has `live` cleared at the clock edge. This keeps an older load from overwriting a newer value.
- **Port select, in priority order:**
  1. `pipe_we` set: drive `WriteReg`=1, `DstReg`=`pipe_reg`, `DstData`=`pipe_data`. The FIFO does not pop.
  2. FIFO not empty: pop the head. If the head is live, drive `WriteReg`=1 with the head's `reg` and `data`. If it is dead, drive `WriteReg`=0 but still pop.
  3. Otherwise: `WriteReg`=0.
- **Idle outputs.** Whenever `WriteReg`=0, `DstReg` and `DstData` are driven to 0.
- **Pending check.** `pendingN` = OR over stored entries of (`live` and `reg` == `chk_regN`). It is combinational and does not include the same-cycle incoming `mem` entry. Checking register 0 always returns 0.
- **Simultaneous push and pop.** Both occur in the same cycle; count is unchanged.

## Timing
- **Reset** (`rst` low, asynchronous): pointers and count go to 0 and all `live` bits clear. Outputs: `mem_ready`=1, `empty`=1, `pending1`=`pending2`=0, `WriteReg`=0, `DstReg`=0, `DstData`=0.
- **Reset mid-operation:** queued loads are discarded.
- **Pipeline write:** zero latency; outputs are combinational from the `pipe_*` inputs.
- **Load return latency:** at least 1 cycle from handshake to `WriteReg`. Without bypass, a load is written in the first cycle after the handshake in which `pipe_we`=0 and it is at the head.
- **Full FIFO:** `mem_ready`=0 for at least one cycle. It returns to 1 the cycle after a pop.
- **Stall window:** `pending` drops in the cycle after the entry pops. The register file's internal read bypass covers the pop cycle itself.

## Configuration
- **`WBQ_BYPASS_EN` defined:** the FIFO goes directly to the write port when all of the following hold: the FIFO is empty, `pipe_we`=0, `mem_valid`=1 and `mem_reg` ≠ 0.
  - The load is then written in the same cycle and is not enqueued.
  - `mem_ready` stays 1.
  - Latency is 0.
- **`WBQ_BYPASS_EN` undefined:** every accepted load is enqueued, giving a minimum latency of 1.

## Structure
- **Shared package `wb_pkg`:** `REG_W`, `DATA_W`, the `wbq_entry_t` struct `{live, reg, data}`, and the constant `REG_ZERO` = 0.
- **Sub-module `wbq_storage`:** the entry array with tail write, combinational head read, parallel squash-by-register, and the two-port pending compare.
- **Top level:** pointers, count, handshake and port-select logic.

## Test plan
- **Reset, then a single load:** after reset, `mem_valid` with R3 = 0x1234 and `pipe_we`=0.
  - Without bypass: `WriteReg`=1, `DstReg`=3, `DstData`=0x1234 one cycle later.
  - With `WBQ_BYPASS_EN`: the same write appears in the same cycle.
- **Priority:** queue holds R5 = 0xAAAA; `pipe_we` writes R2 = 0x0001 for 3 cycles. Expect 3 cycles of R2 writes, then R5 = 0xAAAA in the 4th, with `pending` for R5 high until that write.
- **Squash:** queue holds R7 = 0x1111, then `pipe_we` writes R7 = 0x2222. Expect the R7 entry to pop with `WriteReg`=0 and the register file to keep 0x2222.
- **Full:** hold `pipe_we`=1 and offer 5 loads to R1–R5. Expect `mem_ready`=0 after 4 acceptances; release `pipe_we` and expect writes R1–R4 in order, then R5 accepted and written.
- **Writes to R0:** a load to R0 is accepted and not written; `pending` for R0 stays 0.
- **Mid-operation reset:** assert `rst` low with 3 entries queued. Expect `empty`=1, `WriteReg`=0 and no further writes.
